// File: rtl/load_scoreboard_if.sv
// Hazard-tracker bus: ID-stage instruction, EX handshake, flush, LSU completion
// and the scoreboard's stall/status outputs, bundled for the load scoreboard.
interface load_scoreboard_if #(
  parameter int MAX_OUTSTANDING = 4,
  parameter int CNT_W           = $clog2(MAX_OUTSTANDING + 1),
  parameter int STALL_CNT_W     = 32
);
  logic [31:0]            i_instr_ID;
  logic                   i_id_valid;
  logic                   i_ex_ready;
  logic                   i_flush;
  logic                   i_ld_done_valid;
  logic [4:0]             i_ld_done_rd;
  logic                   o_stall_ID;
  logic [31:0]            o_busy_mask;
  logic [CNT_W-1:0]       o_outstanding;
  logic                   o_err;
  logic [STALL_CNT_W-1:0] o_stall_cnt;

  // Pipeline side: drives the ID/EX/LSU view, observes stall and status.
  modport master (
    output i_instr_ID, i_id_valid, i_ex_ready, i_flush, i_ld_done_valid, i_ld_done_rd,
    input  o_stall_ID, o_busy_mask, o_outstanding, o_err, o_stall_cnt
  );

  // Scoreboard side.
  modport slave (
    input  i_instr_ID, i_id_valid, i_ex_ready, i_flush, i_ld_done_valid, i_ld_done_rd,
    output o_stall_ID, o_busy_mask, o_outstanding, o_err, o_stall_cnt
  );
endinterface

// File: rtl/load_scoreboard.sv
// Load scoreboard: tracks registers targeted by loads that have issued to EX
// but not yet written back, and stalls ID on RAW/WAW hazards against them or
// when the number of loads in flight has reached its limit.
module load_scoreboard #(
  parameter int MAX_OUTSTANDING = 4,
  parameter int CNT_W           = $clog2(MAX_OUTSTANDING + 1),
  parameter int STALL_CNT_W     = 32
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  load_scoreboard_if.slave bus
);

  localparam logic [4:0] OPC_LOAD   = 5'b00000;
  localparam logic [4:0] OPC_STORE  = 5'b01000;
  localparam logic [4:0] OPC_BRANCH = 5'b11000;
  localparam logic [4:0] OPC_OP     = 5'b01100;
  localparam logic [4:0] OPC_LUI    = 5'b01101;
  localparam logic [4:0] OPC_AUIPC  = 5'b00101;
  localparam logic [4:0] OPC_JAL    = 5'b11011;

  logic [4:0]             opc, rd, rs1, rs2;
  logic                   uses_rs1, uses_rs2, writes_rd, is_load;
  logic [31:0]            done_mask, eff_busy, issue_mask;
  logic                   at_max, hazard, stall, issue;
  logic                   done_legal;

  logic [31:0]            busy_q, busy_d;
  logic [CNT_W-1:0]       outstanding_q, outstanding_d;
  logic                   err_q, err_d;
  logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  assign opc = bus.i_instr_ID[6:2];
  assign rd  = bus.i_instr_ID[11:7];
  assign rs1 = bus.i_instr_ID[19:15];
  assign rs2 = bus.i_instr_ID[24:20];

  assign uses_rs1  = !((opc == OPC_LUI) || (opc == OPC_AUIPC) || (opc == OPC_JAL));
  assign uses_rs2  = (opc == OPC_OP) || (opc == OPC_STORE) || (opc == OPC_BRANCH);
  assign writes_rd = !((opc == OPC_STORE) || (opc == OPC_BRANCH));
  assign is_load   = (opc == OPC_LOAD);

  // A completing load frees its register for the ID check in the same cycle.
  // busy_q[0] is never set, so x0 can never produce a hazard.
  assign eff_busy = busy_q & ~done_mask;
  assign at_max   = (outstanding_q == CNT_W'(MAX_OUTSTANDING));

  assign hazard = (uses_rs1 & eff_busy[rs1]) |
                  (uses_rs2 & eff_busy[rs2]) |
                  (writes_rd & eff_busy[rd]) |
                  (is_load & at_max & ~bus.i_ld_done_valid);

  // Held low during reset so the pipeline sees no stall while tracking is void.
  assign stall = i_rst_n & bus.i_id_valid & ~bus.i_flush & hazard;
  assign issue = bus.i_id_valid & ~bus.i_flush & ~stall & bus.i_ex_ready & is_load;

  // A completion only decrements the count when something is actually in flight.
  assign done_legal = bus.i_ld_done_valid && (outstanding_q != '0);

  // Per-register clear/set terms; a new load to a register wins over its completion.
  assign done_mask[0]  = 1'b0;
  assign issue_mask[0] = 1'b0;
  assign busy_d[0]     = 1'b0;
  for (genvar gi = 1; gi < 32; gi++) begin : g_busy
    assign done_mask[gi]  = bus.i_ld_done_valid && (bus.i_ld_done_rd == 5'(gi));
    assign issue_mask[gi] = issue && (rd == 5'(gi));
    assign busy_d[gi]     = (busy_q[gi] & ~done_mask[gi]) | issue_mask[gi];
  end

  // Next-state for the in-flight count, sticky error and stall statistics.
  always_comb begin
    outstanding_d = outstanding_q;
    if (issue && !done_legal) begin
      outstanding_d = outstanding_q + CNT_W'(1);
    end else if (!issue && done_legal) begin
      outstanding_d = outstanding_q - CNT_W'(1);
    end

    err_d = err_q;
    if (bus.i_ld_done_valid &&
        ((outstanding_q == '0) || ((bus.i_ld_done_rd != 5'd0) && !busy_q[bus.i_ld_done_rd]))) begin
      err_d = 1'b1;
    end

    stall_cnt_d = stall_cnt_q;
    if (stall && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + STALL_CNT_W'(1);
    end
  end

  // State registers; reset discards all in-flight tracking immediately.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      busy_q        <= '0;
      outstanding_q <= '0;
      err_q         <= 1'b0;
      stall_cnt_q   <= '0;
    end else begin
      busy_q        <= busy_d;
      outstanding_q <= outstanding_d;
      err_q         <= err_d;
      stall_cnt_q   <= stall_cnt_d;
    end
  end

  assign bus.o_stall_ID    = stall;
  assign bus.o_busy_mask   = busy_q;
  assign bus.o_outstanding = outstanding_q;
  assign bus.o_err         = err_q;
  assign bus.o_stall_cnt   = stall_cnt_q;

endmodule

// File: tb/tb_load_scoreboard.sv
// Directed bench for load_scoreboard: drives RV32I encodings into ID and
// checks stall, busy mask, outstanding count, error and stall counter.
module tb_load_scoreboard;

  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_bad;

  load_scoreboard_if #(.MAX_OUTSTANDING(4)) bus ();

  load_scoreboard #(.MAX_OUTSTANDING(4)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One comparison: counts it, reports a mismatch on one line.
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%08h", tag, got);
    end
  endtask

  function automatic logic [31:0] enc_lw(input logic [4:0] rd, input logic [4:0] rs1);
    return {12'd0, rs1, 3'b010, rd, 7'b0000011};
  endfunction
  function automatic logic [31:0] enc_add(input logic [4:0] rd, input logic [4:0] rs1,
                                          input logic [4:0] rs2);
    return {7'd0, rs2, rs1, 3'b000, rd, 7'b0110011};
  endfunction
  function automatic logic [31:0] enc_lui(input logic [4:0] rd);
    return {20'h12345, rd, 7'b0110111};
  endfunction
  function automatic logic [31:0] enc_sw(input logic [4:0] rs2, input logic [4:0] rs1);
    return {7'd0, rs2, rs1, 3'b010, 5'd0, 7'b0100011};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] instr, input logic valid, input logic flush,
                       input logic dv, input logic [4:0] drd);
    bus.i_instr_ID      = instr;
    bus.i_id_valid      = valid;
    bus.i_flush         = flush;
    bus.i_ld_done_valid = dv;
    bus.i_ld_done_rd    = drd;
    #1;
  endtask

  task automatic idle();
    drive(32'h0000_0013, 1'b0, 1'b0, 1'b0, 5'd0);
  endtask

  initial begin
    n_vec = 0;
    n_bad = 0;
    rst_n = 1'b0;
    bus.i_ex_ready = 1'b1;
    idle();
    // Reset state, even with a load presented in ID.
    drive(enc_lw(5'd5, 5'd2), 1'b1, 1'b0, 1'b0, 5'd0);
    #10;
    chk("rst_stall", 32'(bus.o_stall_ID), 32'd0);
    chk("rst_busy", bus.o_busy_mask, 32'd0);
    chk("rst_outst", 32'(bus.o_outstanding), 32'd0);
    chk("rst_err", 32'(bus.o_err), 32'd0);
    chk("rst_scnt", bus.o_stall_cnt, 32'd0);
    idle();
    tick();
    rst_n = 1'b1;

    // 1: lw x5 then add x6,x5,x1 stalls until x5 completes.
    tick();
    drive(enc_lw(5'd5, 5'd2), 1'b1, 1'b0, 1'b0, 5'd0);
    chk("t1_lw_nostall", 32'(bus.o_stall_ID), 32'd0);
    tick();
    drive(enc_add(5'd6, 5'd5, 5'd1), 1'b1, 1'b0, 1'b0, 5'd0);
    chk("t1_raw_stall", 32'(bus.o_stall_ID), 32'd1);
    chk("t1_busy", bus.o_busy_mask, 32'h0000_0020);
    chk("t1_outst", 32'(bus.o_outstanding), 32'd1);
    tick();
    chk("t1_still_stall", 32'(bus.o_stall_ID), 32'd1);
    tick();
    drive(enc_add(5'd6, 5'd5, 5'd1), 1'b1, 1'b0, 1'b1, 5'd5);
    chk("t1_bypass", 32'(bus.o_stall_ID), 32'd0);
    tick();
    idle();
    chk("t1_busy_clr", bus.o_busy_mask, 32'd0);
    chk("t1_outst0", 32'(bus.o_outstanding), 32'd0);
    chk("t1_scnt", bus.o_stall_cnt, 32'd2);
    chk("t1_err", 32'(bus.o_err), 32'd0);

    // 2: four loads fill the limit; fifth stalls unless a completion lands.
    for (int i = 1; i <= 4; i++) begin
      drive(enc_lw(5'(i), 5'd10), 1'b1, 1'b0, 1'b0, 5'd0);
      tick();
    end
    idle();
    chk("t2_outst4", 32'(bus.o_outstanding), 32'd4);
    chk("t2_busy4", bus.o_busy_mask, 32'h0000_001E);
    drive(enc_lw(5'd7, 5'd10), 1'b1, 1'b0, 1'b0, 5'd0);
    chk("t2_max_stall", 32'(bus.o_stall_ID), 32'd1);
    drive(enc_lw(5'd7, 5'd10), 1'b1, 1'b0, 1'b1, 5'd1);
    chk("t2_max_bypass", 32'(bus.o_stall_ID), 32'd0);
    tick();
    idle();
    chk("t2_outst_hold", 32'(bus.o_outstanding), 32'd4);
    chk("t2_busy_swap", bus.o_busy_mask, 32'h0000_009C);
    chk("t2_scnt", bus.o_stall_cnt, 32'd2);
    drive(32'h0000_0013, 1'b0, 1'b0, 1'b1, 5'd2); tick();
    drive(32'h0000_0013, 1'b0, 1'b0, 1'b1, 5'd3); tick();
    drive(32'h0000_0013, 1'b0, 1'b0, 1'b1, 5'd4); tick();
    drive(32'h0000_0013, 1'b0, 1'b0, 1'b1, 5'd7); tick();
    idle();
    chk("t2_drained", 32'(bus.o_outstanding), 32'd0);
    chk("t2_busy0", bus.o_busy_mask, 32'd0);
    chk("t2_err", 32'(bus.o_err), 32'd0);

    // 3: x8 busy: WAW load and lui stall, store not touching x8 proceeds.
    drive(enc_lw(5'd8, 5'd9), 1'b1, 1'b0, 1'b0, 5'd0);
    tick();
    drive(enc_lw(5'd8, 5'd9), 1'b1, 1'b0, 1'b0, 5'd0);
    chk("t3_waw_lw", 32'(bus.o_stall_ID), 32'd1);
    drive(enc_lui(5'd8), 1'b1, 1'b0, 1'b0, 5'd0);
    chk("t3_waw_lui", 32'(bus.o_stall_ID), 32'd1);
    drive(enc_sw(5'd9, 5'd10), 1'b1, 1'b0, 1'b0, 5'd0);
    chk("t3_sw_ok", 32'(bus.o_stall_ID), 32'd0);
    drive(enc_add(5'd1, 5'd2, 5'd8), 1'b1, 1'b0, 1'b0, 5'd0);
    chk("t3_rs2_raw", 32'(bus.o_stall_ID), 32'd1);
    drive(enc_lui(5'd0), 1'b1, 1'b0, 1'b0, 5'd0);
    chk("t3_x0_ok", 32'(bus.o_stall_ID), 32'd0);
    idle();

    // 4: flush kills the ID instruction: no stall, no issue, busy kept.
    drive(enc_lw(5'd3, 5'd9), 1'b1, 1'b0, 1'b0, 5'd0);
    tick();
    drive(enc_add(5'd4, 5'd3, 5'd3), 1'b1, 1'b1, 1'b0, 5'd0);
    chk("t4_flush_stall", 32'(bus.o_stall_ID), 32'd0);
    tick();
    drive(enc_lw(5'd11, 5'd9), 1'b1, 1'b1, 1'b0, 5'd0);
    tick();
    idle();
    chk("t4_busy", bus.o_busy_mask, 32'h0000_0108);
    chk("t4_outst", 32'(bus.o_outstanding), 32'd2);
    drive(32'h0000_0013, 1'b0, 1'b0, 1'b1, 5'd3); tick();
    drive(32'h0000_0013, 1'b0, 1'b0, 1'b1, 5'd8); tick();
    idle();
    chk("t4_drained", 32'(bus.o_outstanding), 32'd0);
    chk("t4_scnt", bus.o_stall_cnt, 32'd2);

    // 5: load to x0 counts but sets no busy bit; spurious completion errors.
    drive(enc_lw(5'd0, 5'd1), 1'b1, 1'b0, 1'b0, 5'd0);
    tick();
    idle();
    chk("t5_outst1", 32'(bus.o_outstanding), 32'd1);
    chk("t5_busy0", bus.o_busy_mask, 32'd0);
    drive(32'h0000_0013, 1'b0, 1'b0, 1'b1, 5'd0);
    tick();
    idle();
    chk("t5_outst0", 32'(bus.o_outstanding), 32'd0);
    chk("t5_err0", 32'(bus.o_err), 32'd0);
    drive(32'h0000_0013, 1'b0, 1'b0, 1'b1, 5'd0);
    tick();
    idle();
    chk("t5_err1", 32'(bus.o_err), 32'd1);
    chk("t5_underflow", 32'(bus.o_outstanding), 32'd0);
    tick();
    chk("t5_err_sticky", 32'(bus.o_err), 32'd1);

    // 6: asynchronous reset mid-cycle with three loads in flight.
    for (int i = 1; i <= 3; i++) begin
      drive(enc_lw(5'(i), 5'd10), 1'b1, 1'b0, 1'b0, 5'd0);
      tick();
    end
    drive(enc_add(5'd5, 5'd1, 5'd0), 1'b1, 1'b0, 1'b0, 5'd0);
    chk("t6_pre_outst", 32'(bus.o_outstanding), 32'd3);
    chk("t6_pre_stall", 32'(bus.o_stall_ID), 32'd1);
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_stall", 32'(bus.o_stall_ID), 32'd0);
    chk("t6_busy", bus.o_busy_mask, 32'd0);
    chk("t6_outst", 32'(bus.o_outstanding), 32'd0);
    chk("t6_err", 32'(bus.o_err), 32'd0);
    chk("t6_scnt", bus.o_stall_cnt, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
